// File: rtl/fp_issuer_pkg.sv
// Shared types for the FP64 argument issuer.
// Operand triple bundle and the inf/NaN result test.
package fp_issuer_pkg;

  localparam int FLEN = 64;
  localparam int NE   = 11;
  localparam int NF   = FLEN - NE - 1;

  typedef logic [FLEN-1:0] fp_t;

  typedef struct packed {
    fp_t a;
    fp_t b;
    fp_t c;
  } arg_triple_t;

  function automatic logic is_err(fp_t x);
    return &x[FLEN-2 -: NE];
  endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// Synchronous result FIFO with valid/ready on both sides.
// Pointers carry one extra wrap bit to tell full from empty.
module fp_res_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] out_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign in_rdy_o   = !full;
  assign out_vld_o  = !empty;
  assign out_data_o = mem_q[rd_q[AW-1:0]];

  assign push = in_vld_i & in_rdy_o;
  assign pop  = out_vld_o & out_rdy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= in_data_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop)
        rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/fp_arg_issuer.sv
// Credit-limited operand issuer and in-order result collector for the FP64 core.
// Define FP_ARG_ISSUER_PERF_EN to add the perf_* saturating counters.
module fp_arg_issuer
  import fp_issuer_pkg::*;
#(
  parameter int MAX_OUT  = 8,
  parameter int SEQ_W    = 16,
  parameter int WDOG_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      job_vld,
  output logic                      job_rdy,
  input  logic [FLEN-1:0]           job_a,
  input  logic [FLEN-1:0]           job_b,
  input  logic [FLEN-1:0]           job_c,
  output logic                      arg_vld,
  input  logic                      arg_rdy,
  output logic [FLEN-1:0]           a,
  output logic [FLEN-1:0]           b,
  output logic [FLEN-1:0]           c,
  input  logic                      res_vld,
  output logic                      res_rdy,
  input  logic [FLEN-1:0]           res,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [FLEN-1:0]           out_res,
  output logic [SEQ_W-1:0]          out_seq,
  output logic                      out_err,
  output logic [$clog2(MAX_OUT):0]  inflight,
  output logic                      wdog_err
`ifdef FP_ARG_ISSUER_PERF_EN
  ,
  output logic [31:0]               perf_issued,
  output logic [31:0]               perf_retired,
  output logic [31:0]               perf_credit_stall
`endif
);

  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam int WW = $clog2(WDOG_CYC) + 1;

  logic              slot_vld_q;
  arg_triple_t       slot_q;
  logic [CW-1:0]     infl_q;
  logic [CW-1:0]     infl_d;
  logic [SEQ_W-1:0]  seq_q;
  logic [WW-1:0]     wd_q;
  logic              wdog_q;
  logic              credit_ok;
  logic              job_acc;
  logic              issue;
  logic              pop;
  logic              idle;
  logic              res_hs;
  logic              wd_clr;
  logic              wd_hit;
  logic              fifo_in_vld;

  assign credit_ok = infl_q < CW'(MAX_OUT);
  assign idle      = (infl_q == '0);

  assign arg_vld = slot_vld_q & credit_ok;
  assign job_rdy = !slot_vld_q | (arg_rdy & credit_ok);
  assign job_acc = job_vld & job_rdy;
  assign issue   = arg_vld & arg_rdy;

  assign a = slot_q.a;
  assign b = slot_q.b;
  assign c = slot_q.c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= 1'b0;
      slot_q     <= '0;
    end else if (job_acc) begin
      slot_vld_q <= 1'b1;
      slot_q     <= '{a: job_a, b: job_b, c: job_c};
    end else if (issue) begin
      slot_vld_q <= 1'b0;
    end
  end

  // Results arriving with nothing outstanding are dropped here.
  assign fifo_in_vld = res_vld & !idle;

  fp_res_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (FLEN)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld_i   (fifo_in_vld),
    .in_rdy_o   (res_rdy),
    .in_data_i  (res),
    .out_vld_o  (out_vld),
    .out_rdy_i  (out_rdy),
    .out_data_o (out_res)
  );

  assign pop     = out_vld & out_rdy;
  assign out_err = is_err(out_res);
  assign out_seq = seq_q;

  always_comb begin
    infl_d = infl_q;
    unique case ({issue, pop})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: infl_d = infl_q;
    endcase
  end

  assign res_hs = res_vld & res_rdy;
  assign wd_clr = res_hs | idle;
  assign wd_hit = !wd_clr && (wd_q == WW'(WDOG_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q <= '0;
      seq_q  <= '0;
      wd_q   <= '0;
      wdog_q <= 1'b0;
    end else begin
      infl_q <= infl_d;
      if (pop)
        seq_q <= seq_q + 1'b1;
      if (wd_clr)
        wd_q <= '0;
      else if (wd_q != WW'(WDOG_CYC))
        wd_q <= wd_q + 1'b1;
      if (wd_hit || (res_vld && idle))
        wdog_q <= 1'b1;
    end
  end

  assign inflight = infl_q;
  assign wdog_err = wdog_q;

`ifdef FP_ARG_ISSUER_PERF_EN
  logic [31:0] iss_q;
  logic [31:0] ret_q;
  logic [31:0] stl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q <= '0;
      ret_q <= '0;
      stl_q <= '0;
    end else begin
      if (issue && iss_q != '1)
        iss_q <= iss_q + 32'd1;
      if (pop && ret_q != '1)
        ret_q <= ret_q + 32'd1;
      if (slot_vld_q && !credit_ok && stl_q != '1)
        stl_q <= stl_q + 32'd1;
    end
  end

  assign perf_issued       = iss_q;
  assign perf_retired      = ret_q;
  assign perf_credit_stall = stl_q;
`endif

endmodule
